timer_ctrl: RTL
===============

# timer_ctrl

Sequencing controller for the keypad-set countdown timer. Replaces the ad-hoc negedge toggles on the pause/reset buttons with a clocked state machine. It conditions the raw buttons, validates and latches the preset entered on the keypad, and drives load/decrement strobes to the down-counter. It also drives the running/alarm indicators and the display blink. It sits between the keypad/BCD converter front end and the counter/seven-segment back end.

## Interface
- DEB_CYCLES, 16: clock cycles a button level must stay stable before it is accepted
- ALARM_TICKS, 10: `tick` pulses the ALARM state lasts before auto-return

- clk  in  1  system clock
- reseta  in  1  synchronous, active-high reset
- pause  in  1  raw start/pause push-button, active low, asynchronous
- clr  in  1  raw clear push-button, active low, asynchronous
- cfg  in  1  configure-mode switch (level)
- salve  in  1  keypad value-valid strobe, one cycle
- key_val  in  16  keypad value, BCD m-tens/m-units/s-tens/s-units, [15:12]..[3:0]
- tick  in  1  1 Hz enable from prescaler, one cycle wide
- cnt_zero  in  1  counter value is 0000
- cnt_load  out  1  one-cycle strobe: counter loads `cnt_preset`
- cnt_preset  out  16  latched BCD preset
- cnt_dec  out  1  one-cycle decrement strobe
- blank  out  1  display blank (blink during alarm)
- tim1  out  1  running indicator (RUN)
- tim2  out  1  alarm indicator (ALARM)
- key_err  out  1  one-cycle strobe: rejected keypad value

## Operation
- Button conditioning, per button:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after DEB_CYCLES consecutive equal samples.
  - A debounced 1→0 transition emits a one-cycle press pulse (`p_pause`, `p_clr`).
- States: IDLE, SETUP, READY, RUN, PAUSED, ALARM.
- Preset validity: every nibble ≤ 9, s-tens ≤ 5, m-tens ≤ 5, value ≠ 0000.
- IDLE: `cfg`=1 → SETUP. Button presses are ignored.
- SETUP:
  - `salve` with a valid `key_val` → latch into `cnt_preset`.
  - `salve` with an invalid `key_val` → pulse `key_err`; preset unchanged.
  - `cfg`=0 → READY with `cnt_load`=1 if the preset is nonzero, else → IDLE.
- READY:
  - `p_pause` → RUN.
  - `p_clr` → `cnt_load`, stay in READY.
  - `cfg`=1 → SETUP.
- RUN:
  - On `tick`: if `cnt_zero` → ALARM with no decrement; else `cnt_dec`=1.
  - `p_pause` → PAUSED.
  - `p_clr` → `cnt_load`, READY.
  - `cfg` is ignored.
- PAUSED:
  - `p_pause` → RUN.
  - `p_clr` → `cnt_load`, READY.
  - `tick` is ignored.
- ALARM:
  - `blank` toggles on each `tick`.
  - After ALARM_TICKS ticks, or on any press → READY with `cnt_load`, `blank`=0.
- Precedence:
  - reseta > `p_clr` > `p_pause` > `cfg` > `tick`.
  - In RUN, a simultaneous `tick` and `p_clr` → reload; no decrement.
- `salve` outside SETUP is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `cnt_preset`=0000; all strobes 0; `blank`=0; `tim1`=`tim2`=0.
- Reset clears both debounce counters and sets the debounced levels to 1 (released). A button held low through reset yields one press once it has been stable for DEB_CYCLES after reset.
- Press latency: the press pulse occurs DEB_CYCLES+2 cycles after the raw pin falls and stays low. The state changes on the next edge, and `cnt_load` is asserted in that same cycle.
- `cnt_dec` is asserted in the cycle after the `tick` cycle.
- `key_err` and the preset latch take effect one cycle after `salve`.
- `tim1`/`tim2` follow the registered state with zero added delay.
- The ALARM tick counter clears on ALARM entry.
- Reset mid-operation: the next cycle is IDLE with the preset cleared. No `cnt_load` is issued.

## Structure
- Package `timer_pkg`:
  - state enum
  - BCD-validity function
  - ALARM/DEB defaults
- Sub-module `btn_cond` (synchroniser + debounce + falling-edge pulse, parameter DEB_CYCLES), instantiated twice.
- FSM, preset register and alarm counter live in `timer_ctrl`.

## Test plan
- Reset, cfg=1, salve with 0x0130, cfg=0 → `cnt_preset`=0x0130; one `cnt_load` pulse; state READY.
- In SETUP, salve 0x0075 then 0x1A00 → both rejected with a `key_err` pulse each; `cnt_preset` unchanged.
- READY, pause low for DEB_CYCLES+5 cycles → RUN; `tim1`=1; each `tick` gives `cnt_dec` one cycle later. A 5-cycle glitch on pause → no state change.
- RUN with `cnt_zero`=1 on a `tick` → ALARM; `tim2`=1; no `cnt_dec`. `blank` toggles on each of 10 ticks, then READY with `cnt_load`.
- RUN, pause and clr fall on the same cycle → reload and READY (clr wins); a `tick` in that cycle produces no decrement.
- PAUSED, assert reseta for one cycle → IDLE; preset 0000; no strobes; a following pause press is ignored.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and defaults for the countdown timer sequencing controller.
// Holds the FSM state encoding, the preset validity check and default timing.
package timer_pkg;

  localparam int DEB_DEFAULT   = 16;
  localparam int ALARM_DEFAULT = 10;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READY,
    RUN,
    PAUSED,
    ALARM
  } state_e;

  // mm:ss in BCD; both tens digits are limited to 5 and an all-zero preset is rejected
  function automatic logic bcd_valid(input logic [15:0] v);
    logic ok;
    ok = (v[15:12] <= 4'd5) && (v[11:8] <= 4'd9) &&
         (v[7:4]   <= 4'd5) && (v[3:0]  <= 4'd9);
    return ok && (v != 16'h0000);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Front-end / back-end signal bundle of the timer controller.
// The controller uses the slave view; the driving environment uses the master view.
interface timer_ctrl_if;
  logic        pause;
  logic        clr;
  logic        cfg;
  logic        salve;
  logic [15:0] key_val;
  logic        tick;
  logic        cnt_zero;
  logic        cnt_load;
  logic [15:0] cnt_preset;
  logic        cnt_dec;
  logic        blank;
  logic        tim1;
  logic        tim2;
  logic        key_err;

  modport master (
    output pause, clr, cfg, salve, key_val, tick, cnt_zero,
    input  cnt_load, cnt_preset, cnt_dec, blank, tim1, tim2, key_err
  );

  modport slave (
    input  pause, clr, cfg, salve, key_val, tick, cnt_zero,
    output cnt_load, cnt_preset, cnt_dec, blank, tim1, tim2, key_err
  );
endinterface

// File: rtl/timer_ctrl_btn_cond.sv
// Push-button conditioner: 2-FF synchroniser, debounce counter and a one-cycle
// pulse on each accepted press (debounced 1 -> 0 transition).
module btn_cond #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Any sample equal to the accepted level restarts the stability count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/timer_ctrl.sv
// Sequencing controller for the keypad-set countdown timer: conditions the
// buttons, latches the preset and strobes the down-counter.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_DEFAULT,
  parameter int ALARM_TICKS = ALARM_DEFAULT
) (
  input  logic        clk,
  input  logic        reseta,
  timer_ctrl_if.slave bus
);

  localparam int AW = (ALARM_TICKS > 2) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_e          state_q, state_d;
  logic [15:0]     preset_q, preset_d;
  logic [AW-1:0]   acnt_q, acnt_d;
  logic            load_q, load_d;
  logic            dec_q, dec_d;
  logic            err_q, err_d;
  logic            blank_q, blank_d;
  logic            p_pause, p_clr;

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_pause (
    .clk(clk), .rst_i(reseta), .btn_i(bus.pause), .press_o(p_pause)
  );

  btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk(clk), .rst_i(reseta), .btn_i(bus.clr), .press_o(p_clr)
  );

  always_ff @(posedge clk) begin
    if (reseta) begin
      state_q  <= IDLE;
      preset_q <= '0;
      acnt_q   <= '0;
      load_q   <= 1'b0;
      dec_q    <= 1'b0;
      err_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      acnt_q   <= acnt_d;
      load_q   <= load_d;
      dec_q    <= dec_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
    end
  end

  // Button presses beat cfg and tick; clr beats pause everywhere it matters
  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    acnt_d   = acnt_q;
    load_d   = 1'b0;
    dec_d    = 1'b0;
    err_d    = 1'b0;
    blank_d  = blank_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg) state_d = SETUP;
      end
      SETUP: begin
        if (bus.salve) begin
          if (bcd_valid(bus.key_val)) preset_d = bus.key_val;
          else                        err_d    = 1'b1;
        end
        if (!bus.cfg) begin
          if (preset_d != 16'h0000) begin
            state_d = READY;
            load_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      READY: begin
        if (p_clr)        load_d  = 1'b1;
        else if (p_pause) state_d = RUN;
        else if (bus.cfg) state_d = SETUP;
      end
      RUN: begin
        if (p_clr) begin
          state_d = READY;
          load_d  = 1'b1;
        end else if (p_pause) begin
          state_d = PAUSED;
        end else if (bus.tick) begin
          if (bus.cnt_zero) begin
            state_d = ALARM;
            acnt_d  = '0;
            blank_d = 1'b0;
          end else begin
            dec_d = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (p_clr) begin
          state_d = READY;
          load_d  = 1'b1;
        end else if (p_pause) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (p_clr || p_pause || (bus.tick && acnt_q == ALARM_LAST)) begin
          state_d = READY;
          load_d  = 1'b1;
          blank_d = 1'b0;
        end else if (bus.tick) begin
          acnt_d  = acnt_q + AW'(1);
          blank_d = ~blank_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cnt_load   = load_q;
  assign bus.cnt_preset = preset_q;
  assign bus.cnt_dec    = dec_q;
  assign bus.key_err    = err_q;
  assign bus.blank      = blank_q;
  assign bus.tim1       = (state_q == RUN);
  assign bus.tim2       = (state_q == ALARM);

endmodule
